// File: rtl/instr_sequencer.sv
//------------------------------------------------------------------------------
// instr_sequencer
//   Control-timing generator for the Harvard CPU core. Produces the one-hot
//   phase vector {exec3, exec2, exec1, fetch} for the instruction decoder,
//   holds the instruction register, sizes each instruction's execute phase
//   from its opcode, and provides run/halt/single-step control, a sticky
//   illegal-opcode flag and a retired-instruction counter.
//
//   Ports:
//     clk       in   system clock (rising edge)
//     reset     in   synchronous reset, active-high
//     run       in   level: execute instructions back to back
//     halt_req  in   level: stop at the next instruction boundary
//     step      in   pulse: execute exactly one instruction from idle
//     mem_data  in   program-memory word, sampled at the end of FETCH
//     state     out  one-hot phase, 4'b0000 when idle
//     inst      out  opcode from the instruction register
//     operand   out  low bits of the instruction register
//     busy      out  state != 0
//     halted    out  state == 0
//     illegal   out  sticky: an undefined opcode was executed
//     retired   out  count of completed instructions (wraps)
//
//   Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module instr_sequencer #(
  parameter int IR_WIDTH = 16,
  parameter int RETIRE_W = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                run,
  input  logic                halt_req,
  input  logic                step,
  input  logic [IR_WIDTH-1:0] mem_data,
  output logic [3:0]          state,
  output logic [3:0]          inst,
  output logic [IR_WIDTH-5:0] operand,
  output logic                busy,
  output logic                halted,
  output logic                illegal,
  output logic [RETIRE_W-1:0] retired
);

  localparam logic [3:0] S_IDLE  = 4'b0000;
  localparam logic [3:0] S_FETCH = 4'b0001;
  localparam logic [3:0] S_EX1   = 4'b0010;
  localparam logic [3:0] S_EX2   = 4'b0100;
  localparam logic [3:0] S_EX3   = 4'b1000;

  logic [IR_WIDTH-1:0] ir;
  logic                step_flag;

  logic op_illegal;
  logic op_len3;
  logic op_len4;
  logic last_cycle;
  logic illegal_next;
  logic continue_run;

  assign inst    = ir[IR_WIDTH-1 -: 4];
  assign operand = ir[IR_WIDTH-5:0];
  assign busy    = (state != S_IDLE);
  assign halted  = (state == S_IDLE);

  // Opcode classes: 3 lda / 14 ldr take one extra execute cycle, 13 mul two.
  assign op_illegal = ((inst >= 4'd7) && (inst <= 4'd12)) || (inst == 4'd15);
  assign op_len3    = (inst == 4'd3) || (inst == 4'd14);
  assign op_len4    = (inst == 4'd13);

  assign last_cycle = ((state == S_EX1) && !op_len3 && !op_len4) ||
                      ((state == S_EX2) && op_len3) ||
                      (state == S_EX3);

  // An illegal opcode flagged in this very EX1 must already block the
  // back-to-back continuation at this boundary.
  assign illegal_next = illegal | ((state == S_EX1) & op_illegal);
  assign continue_run = run & ~halt_req & ~step_flag & ~illegal_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      ir        <= '0;
      step_flag <= 1'b0;
      illegal   <= 1'b0;
      retired   <= '0;
    end else begin
      illegal <= illegal_next;
      if (last_cycle) begin
        retired <= retired + 1'b1;
        if (continue_run) begin
          state <= S_FETCH;
        end else begin
          state     <= S_IDLE;
          step_flag <= 1'b0;
        end
      end else begin
        case (state)
          S_IDLE: begin
            if (run && !halt_req && !illegal) begin
              state <= S_FETCH;
            end else if (step && !run) begin
              state     <= S_FETCH;
              step_flag <= 1'b1;
            end
          end
          S_FETCH: begin
            ir    <= mem_data;
            state <= S_EX1;
          end
          S_EX1:   state <= S_EX2;
          S_EX2:   state <= S_EX3;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_instr_sequencer.sv
//------------------------------------------------------------------------------
// tb_instr_sequencer
//   Self-checking bench: a directed vector table, hand-written corner-case
//   sequences and a randomized phase, all checked every cycle against an
//   instruction-level reference model (active flag + position in instruction).
//   The counter width is reduced so the wrap case stays short.
//
//   Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_instr_sequencer;

  localparam int IW = 16;
  localparam int RW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, run, halt_req, step;
  logic [IW-1:0] mem_data;
  logic [3:0]    state, inst;
  logic [IW-5:0] operand;
  logic          busy, halted, illegal;
  logic [RW-1:0] retired;

  instr_sequencer #(.IR_WIDTH(IW), .RETIRE_W(RW)) dut (
    .clk      (clk),
    .reset    (reset),
    .run      (run),
    .halt_req (halt_req),
    .step     (step),
    .mem_data (mem_data),
    .state    (state),
    .inst     (inst),
    .operand  (operand),
    .busy     (busy),
    .halted   (halted),
    .illegal  (illegal),
    .retired  (retired)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: instruction-level view.
  bit            m_active, m_stepmode, m_ill;
  int            m_pos;
  logic [IW-1:0] m_ir;
  int            m_ret;
  int            LEN [16] = '{2, 2, 2, 3, 2, 2, 2, 2, 2, 2, 2, 2, 2, 4, 3, 2};

  function automatic bit is_ill(int op);
    return ((op >= 7) && (op <= 12)) || (op == 15);
  endfunction

  task automatic model_step();
    int op;
    if (reset) begin
      m_active = 0; m_stepmode = 0; m_ill = 0; m_pos = 0; m_ir = '0; m_ret = 0;
    end else if (!m_active) begin
      if (run && !halt_req && !m_ill) begin
        m_active = 1; m_pos = 0;
      end else if (step && !run) begin
        m_active = 1; m_pos = 0; m_stepmode = 1;
      end
    end else if (m_pos == 0) begin
      m_ir  = mem_data;
      m_pos = 1;
    end else begin
      op = int'(m_ir[IW-1 -: 4]);
      if (m_pos == 1 && is_ill(op)) m_ill = 1;
      if (m_pos == LEN[op] - 1) begin
        m_ret = (m_ret + 1) % (1 << RW);
        if (run && !halt_req && !m_stepmode && !m_ill) m_pos = 0;
        else begin
          m_active = 0; m_stepmode = 0;
        end
      end else begin
        m_pos++;
      end
    end
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_model();
    logic [3:0] es;
    es = m_active ? 4'(1 << m_pos) : 4'b0000;
    chk("state",   32'(state),   32'(es));
    chk("inst",    32'(inst),    32'(m_ir[IW-1 -: 4]));
    chk("operand", 32'(operand), 32'(m_ir[IW-5:0]));
    chk("busy",    32'(busy),    32'(m_active));
    chk("halted",  32'(halted),  32'(!m_active));
    chk("illegal", 32'(illegal), 32'(m_ill));
    chk("retired", 32'(retired), 32'(m_ret));
  endtask

  // One clock: drive inputs, advance model at the edge, compare 1ns later.
  task automatic cycle(input logic r, input logic ru, input logic h,
                       input logic s, input logic [IW-1:0] m);
    reset = r; run = ru; halt_req = h; step = s; mem_data = m;
    @(posedge clk);
    model_step();
    #1;
    compare_model();
  endtask

  typedef struct packed {
    logic          r, ru, h, s;
    logic [IW-1:0] mem;
    logic [3:0]    st;
    logic [3:0]    op;
    logic [RW-1:0] ret;
  } vec_t;

  vec_t vec [13];

  initial begin
    reset = 1'b1; run = 1'b0; halt_req = 1'b0; step = 1'b0; mem_data = '0;

    // Directed program: jmp, lda, mul, sta.
    vec[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 4'b0000, 4'h0, 8'd0};
    vec[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 4'b0001, 4'h0, 8'd0};
    vec[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h1234, 4'b0010, 4'h1, 8'd0};
    vec[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 4'b0001, 4'h1, 8'd1};
    vec[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h3ABC, 4'b0010, 4'h3, 8'd1};
    vec[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 4'b0100, 4'h3, 8'd1};
    vec[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 4'b0001, 4'h3, 8'd2};
    vec[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 16'hD001, 4'b0010, 4'hD, 8'd2};
    vec[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 4'b0100, 4'hD, 8'd2};
    vec[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 4'b1000, 4'hD, 8'd2};
    vec[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 4'b0001, 4'hD, 8'd3};
    vec[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 4'b0010, 4'h0, 8'd3};
    vec[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 4'b0000, 4'h0, 8'd4};

    for (int i = 0; i < 13; i++) begin
      cycle(vec[i].r, vec[i].ru, vec[i].h, vec[i].s, vec[i].mem);
      chk($sformatf("vec%0d_state", i), 32'(state),   32'(vec[i].st));
      chk($sformatf("vec%0d_inst", i),  32'(inst),    32'(vec[i].op));
      chk($sformatf("vec%0d_ret", i),   32'(retired), 32'(vec[i].ret));
    end
    chk("reset_halted", 32'(halted), 32'd1);

    // halt_req raised during EX1 of a mul: the mul still completes.
    cycle(0, 1, 0, 0, 16'h0000);
    cycle(0, 1, 0, 0, 16'hD000);
    cycle(0, 1, 1, 0, 16'h0000);
    chk("halt_ex2", 32'(state), 32'b0100);
    cycle(0, 1, 1, 0, 16'h0000);
    chk("halt_ex3", 32'(state), 32'b1000);
    cycle(0, 1, 1, 0, 16'h0000);
    chk("halt_idle", 32'(state), 32'b0000);
    chk("halt_halted", 32'(halted), 32'd1);
    chk("halt_ret", 32'(retired), 32'd5);
    cycle(0, 1, 1, 0, 16'h0000);
    chk("halt_run_idle", 32'(state), 32'b0000);

    // Single-step a ldr; a second step during EX1 is ignored.
    cycle(0, 0, 0, 1, 16'h0000);
    chk("step_fetch", 32'(state), 32'b0001);
    cycle(0, 0, 0, 0, 16'hE055);
    cycle(0, 0, 0, 1, 16'h0000);
    chk("step_ex2", 32'(state), 32'b0100);
    cycle(0, 0, 0, 0, 16'h0000);
    chk("step_idle", 32'(state), 32'b0000);
    chk("step_operand", 32'(operand), 32'h055);
    cycle(0, 0, 0, 0, 16'h0000);
    chk("step_stays_idle", 32'(state), 32'b0000);

    // Illegal opcode: 2-cycle no-op, sticky flag, run blocked, step allowed.
    cycle(0, 1, 0, 0, 16'h0000);
    cycle(0, 1, 0, 0, 16'h9000);
    cycle(0, 1, 0, 0, 16'h0000);
    chk("ill_idle", 32'(state), 32'b0000);
    chk("ill_flag", 32'(illegal), 32'd1);
    cycle(0, 1, 0, 0, 16'h0000);
    chk("ill_run_blocked", 32'(state), 32'b0000);
    cycle(0, 0, 0, 1, 16'h0000);
    chk("ill_step_fetch", 32'(state), 32'b0001);
    cycle(0, 0, 0, 0, 16'h1000);
    cycle(0, 0, 0, 0, 16'h0000);
    chk("ill_step_done", 32'(retired), 32'd8);
    cycle(1, 0, 0, 0, 16'h0000);
    chk("ill_reset", 32'(illegal), 32'd0);

    // Counter wrap with sta instructions (2 cycles each).
    for (int i = 0; i < 511; i++) cycle(0, 1, 0, 0, 16'h0000);
    chk("wrap_allones", 32'(retired), 32'hFF);
    cycle(0, 1, 0, 0, 16'h0000);
    cycle(0, 1, 0, 0, 16'h0000);
    chk("wrap_zero", 32'(retired), 32'h00);
    cycle(0, 0, 0, 0, 16'h0000);
    cycle(0, 0, 0, 0, 16'h0000);

    // Reset during EX2 of a lda, run held high.
    cycle(0, 1, 0, 0, 16'h0000);
    cycle(0, 1, 0, 0, 16'h3123);
    cycle(0, 1, 0, 0, 16'h0000);
    chk("rst_mid_ex2", 32'(state), 32'b0100);
    cycle(1, 1, 0, 0, 16'h0000);
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_inst", 32'(inst), 32'd0);
    chk("rst_operand", 32'(operand), 32'd0);
    chk("rst_retired", 32'(retired), 32'd0);
    cycle(0, 1, 0, 0, 16'h0000);
    chk("rst_then_fetch", 32'(state), 32'b0001);

    // Randomized phase against the model.
    for (int i = 0; i < 3000; i++) begin
      logic [IW-1:0] m;
      logic [3:0]    op;
      int            legal [7] = '{0, 1, 2, 3, 4, 5, 6};
      if ($urandom_range(3) != 0) begin
        case ($urandom_range(9))
          0:       op = 4'd13;
          1:       op = 4'd14;
          default: op = 4'(legal[$urandom_range(6)]);
        endcase
      end else begin
        op = 4'($urandom_range(15));
      end
      m = {op, 12'($urandom)};
      cycle(($urandom_range(49) == 0), ($urandom_range(99) < 85),
            ($urandom_range(9) == 0), ($urandom_range(7) == 0), m);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/instr_sequencer.md
# instr_sequencer

Control-timing generator for the Harvard CPU core. Produces the one-hot `state` vector (fetch, exec1, exec2, exec3) consumed by the instruction decoder, holds the instruction register that drives the decoder's `inst` opcode input, and sizes each instruction's execute phase to match the decoder's PC-increment rules. Also provides run/halt/single-step control, sticky illegal-opcode detection and a retired-instruction counter.

## Interface
Parameters:
- `IR_WIDTH`, 16: instruction word width; opcode in bits [IR_WIDTH-1 : IR_WIDTH-4].
- `RETIRE_W`, 16: width of the retired-instruction counter.

Ports:
- `clk`  in  1  system clock. One clock domain; everything is on its rising edge.
- `reset`  in  1  synchronous reset, active-high.
- `run`  in  1  level input; while high, the block executes instructions back to back.
- `halt_req`  in  1  level input; stops execution at the next instruction boundary.
- `step`  in  1  single-cycle pulse; executes exactly one instruction from idle.
- `mem_data`  in  IR_WIDTH  program-memory word; sampled at the end of the fetch cycle.
- `state`  out  4  one-hot phase {exec3, exec2, exec1, fetch}; 4'b0000 when idle.
- `inst`  out  4  opcode from the instruction register, to the decoder.
- `operand`  out  IR_WIDTH-4  low bits of the instruction register.
- `busy`  out  1  high when `state` is not 0.
- `halted`  out  1  high when `state` is 0.
- `illegal`  out  1  sticky flag: an undefined opcode was executed.
- `retired`  out  RETIRE_W  count of completed instructions.

## Operation
- States: IDLE (0000), FETCH (0001), EX1 (0010), EX2 (0100), EX3 (1000). `state` is a direct register output.
- Instruction length, from the opcode latched in FETCH:
  - 2 cycles (FETCH, EX1): opcodes 0 sta, 1 jmp, 2 stp, 4 jms, 5 bbl, 6 jeq, and all illegal opcodes.
  - 3 cycles (FETCH, EX1, EX2): 3 lda, 14 ldr.
  - 4 cycles (FETCH, EX1, EX2, EX3): 13 mul.
- Illegal opcodes are 7–12 and 15.
  - Each executes as a 2-cycle no-op; the decoder asserts no strobes for it.
  - It sets `illegal`, which only `reset` clears.
- IDLE → FETCH when any of:
  - `run`=1 and `halt_req`=0 and `illegal`=0;
  - `step`=1 and `run`=0. This also sets an internal step flag.
- Last execute cycle → FETCH when `run`=1, `halt_req`=0, step flag clear and `illegal`=0 (including an illegal opcode being set this cycle). Otherwise → IDLE, and the step flag clears.
- The instruction register loads `mem_data` at the end of FETCH.
  - `inst`/`operand` are valid from EX1 through the last execute cycle.
  - During FETCH and IDLE they hold the previous instruction.
- `retired` increments by 1 at the end of each instruction's last execute cycle. It wraps from all-ones to 0.
- Boundary rules:
  - An instruction in progress always completes, even if `run` drops or `halt_req` rises mid-instruction. Stopping happens only at the boundary.
  - `step` while busy is ignored. `step` with `run`=1 is ignored.
  - `step` with `illegal`=1 is allowed and runs one instruction.
  - `halt_req` and `run` both high in IDLE: the block stays in IDLE.
  - `reset` in any state: next cycle `state`=0, `inst`=0, `operand`=0, `illegal`=0, `retired`=0, step flag clear. No partial instruction resumes.

## Timing
- Reset values: `state`=0000, `inst`=0, `operand`=0, `busy`=0, `halted`=1, `illegal`=0, `retired`=0.
- Start latency: `run` sampled high in IDLE gives FETCH on the next cycle.
- Back-to-back execution: the last execute cycle is followed immediately by FETCH, with no idle bubble.
- `illegal` rises the cycle after EX1 of the offending instruction.
- `retired` updates the cycle after the last execute cycle, in the same cycle as the next FETCH or IDLE.
- `busy`/`halted` are decoded from the `state` register and carry no extra latency.

## Test plan
- Reset, then `run`=1 with memory holding jmp (0x1xxx), lda (0x3xxx), mul (0xDxxx) → `state` sequence 0001,0010, 0001,0010,0100, 0001,0010,0100,1000, 0001; `retired`=3 after the mul's EX3.
- Start a mul, then raise `halt_req` during EX1 → EX2 and EX3 still occur, then `state`=0000 with `halted`=1; `retired` increments once.
- With `run`=0, pulse `step` over a ldr (0xExxx) → exactly FETCH, EX1, EX2, then IDLE. A second `step` pulse during EX1 has no effect.
- Run with opcode 0x9 → 2-cycle no-op, `illegal`=1, then IDLE even though `run`=1. `step` then executes one further instruction. `reset` clears `illegal`.
- Preload `retired`=0xFFFF by running 65535 sta instructions, then one more → `retired`=0x0000.
- Assert `reset` during EX2 of a lda → next cycle all outputs at reset values. With `run`=1, FETCH follows one cycle after `reset` drops.
